demux1_to_8_32_reg: RTL and testbench

- Registered 1-to-8 distributor. It is the write-side counterpart of the 8-to-1 32-bit read selector in the datapath.
- A single 32-bit producer stream is steered by a 3-bit select (s2,s1,s0) into one of eight per-destination holding registers.
- Each destination drains its register through its own valid/ready handshake.
- Sits between the ALU/result bus and multiple consumer units, such as writeback staging or forwarding latches.

---
 rtl/demux1_to_8_32_reg_if.sv | 31 +++
 rtl/demux1_to_8_32_reg.sv | 48 ++++
 tb/tb_demux1_to_8_32_reg.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/demux1_to_8_32_reg_if.sv
// demux1_to_8_32_reg_if: producer stream, select bits and the eight consumer channels.
interface demux1_to_8_32_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic             s0;
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out5;
    logic [WIDTH-1:0] out6;
    logic [WIDTH-1:0] out7;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic [CNT_W-1:0] xfer_count;
    modport master (
        output in, in_valid, s0, s1, s2, out_ready,
        input  in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid, xfer_count
    );
    modport slave (
        input  in, in_valid, s0, s1, s2, out_ready,
        output in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid, xfer_count
    );
endinterface

// File: rtl/demux1_to_8_32_reg.sv
// demux1_to_8_32_reg: steers one valid/ready word stream into eight registered output channels.
module demux1_to_8_32_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic                 clk,
    input logic                 reset,
    demux1_to_8_32_reg_if.slave bus
);
    logic [2:0]       sel;
    logic [7:0]       full;
    logic [WIDTH-1:0] data [8];
    logic [CNT_W-1:0] cnt;
    logic             rdy;
    logic             acc;
    assign sel = {bus.s2, bus.s1, bus.s0};
    // a full channel still accepts when its consumer drains in the same cycle
    assign rdy = ~full[sel] | bus.out_ready[sel];
    assign acc = bus.in_valid & rdy;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= '0;
            cnt  <= '0;
            for (int k = 0; k < 8; k++) data[k] <= '0;
        end else begin
            cnt <= cnt + CNT_W'(acc);
            for (int k = 0; k < 8; k++) begin
                if (acc && sel == 3'(k)) begin
                    data[k] <= bus.in;
                    full[k] <= 1'b1;
                end else if (bus.out_ready[k]) begin
                    full[k] <= 1'b0;
                end
            end
        end
    end
    assign bus.in_ready   = rdy;
    assign bus.out_valid  = full;
    assign bus.xfer_count = cnt;
    assign bus.out0 = data[0];
    assign bus.out1 = data[1];
    assign bus.out2 = data[2];
    assign bus.out3 = data[3];
    assign bus.out4 = data[4];
    assign bus.out5 = data[5];
    assign bus.out6 = data[6];
    assign bus.out7 = data[7];
endmodule

// File: tb/tb_demux1_to_8_32_reg.sv
// tb_demux1_to_8_32_reg: directed plan plus random traffic against an array-based channel model.
module tb_demux1_to_8_32_reg;
    logic clk = 0;
    logic reset = 1;
    int checks = 0;
    int failures = 0;
    demux1_to_8_32_reg_if bus ();
    demux1_to_8_32_reg dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    logic [31:0] m_data [8];
    logic [7:0]  m_full;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_out(input int k);
        case (k)
            0: return bus.out0;
            1: return bus.out1;
            2: return bus.out2;
            3: return bus.out3;
            4: return bus.out4;
            5: return bus.out5;
            6: return bus.out6;
            default: return bus.out7;
        endcase
    endfunction

    task automatic model_reset();
        m_full = '0;
        m_cnt = 0;
        for (int k = 0; k < 8; k++) m_data[k] = '0;
    endtask

    function automatic bit model_ready(input logic [2:0] sel, input logic [7:0] ordy);
        return !m_full[sel] || ordy[sel];
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_full));
        chk({tag, ".xfer_count"}, 64'(bus.xfer_count), 64'(m_cnt % 65536));
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s.out%0d", tag, k), 64'(get_out(k)), 64'(m_data[k]));
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] d, input logic [7:0] ordy);
        bus.in_valid = v;
        {bus.s2, bus.s1, bus.s0} = sel;
        bus.in = d;
        bus.out_ready = ordy;
    endtask

    // one clock: check ready before the edge, advance the model, check registers after
    task automatic step(input string tag, input logic v, input logic [2:0] sel, input logic [31:0] d, input logic [7:0] ordy);
        bit acc;
        drive(v, sel, d, ordy);
        #1;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(model_ready(sel, ordy)));
        acc = v && model_ready(sel, ordy);
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (acc && sel == 3'(k)) begin
                m_data[k] = d;
                m_full[k] = 1'b1;
            end else if (ordy[k]) begin
                m_full[k] = 1'b0;
            end
        end
        if (acc) m_cnt++;
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        drive(0, 3'd0, '0, 8'h00);
        #1 reset = 1;
        model_reset();
        #1;
        compare_all(tag);
        for (int s = 0; s < 8; s++) begin
            {bus.s2, bus.s1, bus.s0} = 3'(s);
            #1 chk($sformatf("%s.in_ready%0d", tag, s), 64'(bus.in_ready), 64'd1);
        end
        @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        drive(0, 3'd0, '0, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
        reset = 0;

        step("load3", 1, 3'd3, 32'hDEADBEEF, 8'h00);
        chk("load3.valid", 64'(bus.out_valid), 64'h08);
        chk("load3.data", 64'(bus.out3), 64'hDEADBEEF);
        chk("load3.cnt", 64'(bus.xfer_count), 64'd1);
        repeat (5) step("idle", 0, 3'd0, 32'h0, 8'h00);
        chk("idle.valid", 64'(bus.out_valid), 64'h08);

        step("stall3", 1, 3'd3, 32'h11111111, 8'h00);
        chk("stall3.data", 64'(bus.out3), 64'hDEADBEEF);
        drive(1, 3'd3, 32'h11111111, 8'h08);
        #1 chk("refill3.in_ready", 64'(bus.in_ready), 64'd1);
        step("refill3", 1, 3'd3, 32'h11111111, 8'h08);
        chk("refill3.valid", 64'(bus.out_valid), 64'h08);
        chk("refill3.data", 64'(bus.out3), 64'h11111111);
        chk("refill3.cnt", 64'(bus.xfer_count), 64'd2);

        step("load5", 1, 3'd5, 32'hA5A5A5A5, 8'h00);
        chk("load5.valid", 64'(bus.out_valid), 64'h28);
        chk("load5.data", 64'(bus.out5), 64'hA5A5A5A5);

        async_reset("rst1");
        for (int k = 0; k < 8; k++) step($sformatf("sweep%0d", k), 1, 3'(k), 32'(k + 1), 8'h00);
        chk("sweep.valid", 64'(bus.out_valid), 64'hFF);
        step("drain", 0, 3'd0, 32'h0, 8'hFF);
        chk("drain.valid", 64'(bus.out_valid), 64'h00);
        chk("drain.cnt", 64'(bus.xfer_count), 64'd8);
        chk("drain.persist7", 64'(bus.out7), 64'd8);

        for (int k = 0; k < 8; k++) step("refill", 1, 3'(k), $urandom, 8'h00);
        chk("refill.valid", 64'(bus.out_valid), 64'hFF);
        async_reset("rst_mid");

        for (int i = 0; i < 3000; i++)
            step("rand", 1'($urandom), 3'($urandom), $urandom, 8'($urandom));

        async_reset("rst_wrap");
        drive(1, 3'd0, 32'hC0FFEE00, 8'h01);
        repeat (65535) @(posedge clk);
        m_full[0] = 1'b1;
        m_data[0] = 32'hC0FFEE00;
        m_cnt = 65535;
        #1;
        compare_all("pre_wrap");
        chk("pre_wrap.cnt", 64'(bus.xfer_count), 64'hFFFF);
        step("wrap", 1, 3'd0, 32'h12345678, 8'h01);
        chk("wrap.cnt", 64'(bus.xfer_count), 64'd0);
        chk("wrap.data", 64'(bus.out0), 64'h12345678);
        chk("wrap.valid", 64'(bus.out_valid), 64'h01);
        step("wrap_drain", 0, 3'd0, 32'h0, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
